imem_loader: RTL
================

# imem_loader

Boot-time program loader that writes the instruction memory of the single-cycle processor. It receives a byte stream over a valid/ready handshake, assembles little-endian N-bit instruction words, and issues one write per word into a 64-entry instruction RAM. While loading, it holds the CPU in reset, then releases it. It is the write-side counterpart of the instruction-fetch read port.

## Interface
- N, 32, instruction word width in bits; must be a multiple of 8; bytes per word B = N/8
- ADDR_W, 6, instruction memory address width; depth D = 2^ADDR_W (64)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  incoming stream byte
- rx_valid  in  1  rx_data is valid this cycle
- rx_ready  out  1  loader accepts a byte this cycle
- we  out  1  instruction memory write enable, one-cycle pulse per word
- waddr  out  ADDR_W  write word address
- wdata  out  N  write word data
- cpu_hold  out  1  holds the processor in reset while high
- done  out  1  load completed successfully; sticky until reset
- err  out  1  load aborted; sticky until reset

## Operation
- Stream format: header byte W (word count), then W×B data bytes, least-significant byte of each word first, optionally followed by one checksum byte (see Configuration).
- A byte transfers on a rising edge with rx_valid && rx_ready. rx_ready is a combinational function of the state only and never depends on rx_valid.
- States:
  - HDR: rx_ready=1. On transfer, if W==0 or W>D, go to ERR. Otherwise latch W, clear the word counter and byte index, and go to BYTE.
  - BYTE: rx_ready=1. On transfer, shift the byte into lane byte_idx of the word register. On the transfer of byte B-1, go to WRITE.
  - WRITE: rx_ready=0. Drive we=1 for exactly one cycle with waddr=word counter and wdata=assembled word, then increment the word counter. If the written word was word W-1, go to CSUM when the checksum feature is enabled, otherwise go to DONE. Else return to BYTE.
  - CSUM: rx_ready=1. This state exists only when the checksum feature is enabled.
  - DONE: rx_ready=0, done=1, cpu_hold=0. Terminal until reset.
  - ERR: rx_ready=0, err=1, cpu_hold=1. Terminal until reset.
- Word counter width is ADDR_W+1 so it can represent W=D. waddr carries the low ADDR_W bits and never wraps during a valid load.
- Bytes offered in DONE or ERR are never accepted.
- Reset mid-load discards the partial word, returns to HDR, and asserts cpu_hold. Words already written remain in memory but count as stale.

## Timing
- Reset values: state=HDR, rx_ready=1, we=0, waddr=0, wdata=0, cpu_hold=1, done=0, err=0.
- The write pulse occurs in the cycle after the edge that accepted the last byte of a word. waddr and wdata hold their values until the next write.
- The minimum load time is 1 + W×(B+1) cycles, plus 1 cycle with checksum, from the first accepted byte to done=1.
- rx_valid gaps simply stall the FSM. No timeout exists.
- done and err rise in the cycle after the decisive transfer or write. cpu_hold falls in the same cycle that done rises.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last WRITE, the FSM enters CSUM and accepts one byte.
  - If that byte equals the XOR of all W×B data bytes, go to DONE; otherwise go to ERR.
  - The XOR accumulator is cleared in HDR.
- Not defined: no CSUM state and no accumulator. The last WRITE goes directly to DONE.

## Test plan
- Load W=2 with bytes 00 00 00 F8 01 80 00 F8 → we pulses at waddr=0 with wdata=32'hf8000000, then at waddr=1 with 32'hf8008001; done=1 and cpu_hold=0; further rx_valid is ignored.
- Header W=0, and separately W=65 → err=1 next cycle, cpu_hold=1, rx_ready=0, no we pulse.
- Load W=1 with rx_valid toggling every other cycle → wdata is identical to the gap-free case, and rx_ready=0 exactly during WRITE.
- Load W=64 → 64 we pulses with waddr 0..63 and no wrap; done=1 after the 64th write.
- Assert reset after 6 of 8 bytes of a W=2 load → state HDR and cpu_hold=1; a fresh W=1 load writes waddr=0 correctly.
- With IMEM_LOADER_CHECKSUM_EN: W=1, bytes 01 02 03 04, checksum 04 → done=1; checksum 05 → err=1.

Source files
------------

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader for the instruction memory of the single-cycle
// processor. A byte stream arrives over a valid/ready handshake:
//
//   header W (word count, 1..2^ADDR_W), then W*B data bytes, each word
//   least-significant byte first, then (checksum build only) one XOR byte.
//
// Each assembled word is written into the instruction RAM with a one-cycle
// write pulse. The processor is held in reset until the load completes.
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN - when defined, a trailing checksum byte is
//   expected after the last word and must equal the XOR of all data bytes.
//   If it does not match, the load ends in the error state.
//
// Parameters:
//   N       instruction word width in bits (multiple of 8)
//   ADDR_W  instruction memory address width (depth 2^ADDR_W)
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   rx_data   in   stream byte
//   rx_valid  in   rx_data valid this cycle
//   rx_ready  out  loader accepts a byte this cycle (function of state only)
//   we        out  instruction memory write enable, one pulse per word
//   waddr     out  write word address, held until the next write
//   wdata     out  write word data, held until the next write
//   cpu_hold  out  processor held in reset while high
//   done      out  load completed, sticky until reset
//   err       out  load aborted, sticky until reset
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int N      = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [N-1:0]      wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int B     = N / 8;
    localparam int D     = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;               // must be able to hold W == D
    localparam int IDX_W = (B > 1) ? $clog2(B) : 1;

    typedef enum logic [2:0] {
        S_HDR,
        S_BYTE,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wcount_q, wcount_d;          // latched header W
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;      // index of the word being built
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;      // lane of the next byte
    logic [N-1:0]       word_q, word_d;              // assembly register
    logic [N-1:0]       word_lane;                   // assembly register with this byte merged
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [N-1:0]       wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic xfer;
    logic byte_xfer;
    logic last_byte;
    logic last_word;
    logic hdr_bad;

    assign xfer      = rx_valid && rx_ready;
    assign byte_xfer = xfer && (state_q == S_BYTE);
    assign last_byte = (byte_idx_q == IDX_W'(B - 1));
    assign last_word = (word_cnt_q == (wcount_q - CNT_W'(1)));
    assign hdr_bad   = (rx_data == 8'd0) || (int'(rx_data) > D);

    // Per-lane merge of the incoming byte into the word being assembled.
    generate
        for (genvar gi = 0; gi < B; gi++) begin : g_lane
            assign word_lane[gi*8 +: 8] = (byte_xfer && (byte_idx_q == IDX_W'(gi)))
                                          ? rx_data : word_q[gi*8 +: 8];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_HDR;
            wcount_q   <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wcount_q   <= wcount_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wcount_d   = wcount_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_lane;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        rx_ready = 1'b0;
        we       = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        err      = 1'b0;

        unique case (state_q)
            S_HDR: begin
                rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_d   = '0;
`endif
                if (xfer) begin
                    if (hdr_bad) begin
                        state_d = S_ERR;
                    end else begin
                        wcount_d   = CNT_W'(rx_data);
                        word_cnt_d = '0;
                        byte_idx_d = '0;
                        word_d     = '0;
                        state_d    = S_BYTE;
                    end
                end
            end

            S_BYTE: begin
                rx_ready = 1'b1;
                if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (last_byte) begin
                        // Capture the complete word into the output registers
                        // now so the write pulse next cycle sees it, and so
                        // waddr/wdata stay put until the following write.
                        byte_idx_d = '0;
                        waddr_d    = word_cnt_q[ADDR_W-1:0];
                        wdata_d    = word_lane;
                        state_d    = S_WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end
            end

            S_WRITE: begin
                we         = 1'b1;
                word_cnt_d = word_cnt_q + CNT_W'(1);
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_BYTE;
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                rx_ready = 1'b1;
                if (xfer) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif

            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end

            S_ERR: begin
                err = 1'b1;
            end

            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule
